unit_l_pipe: RTL and testbench
==============================

// Module: unit_l_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 32-bit combinational logic unit: bitwise op on two WIDTH-bit operands.
//  Eight ops instead of three. Valid/ready handshake on both sides, 2-cycle latency, full throughput.
//  Also counts completed ops. Sits between operand fetch and writeback in the ALU datapath.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=1)
//  CNT_W  16  width of completed-op counter (>=1)
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      operand beat valid
//  in_ready    out  1      block accepts operand beat this cycle
//  in_op       in   3      op select (encoding below)
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  out_valid   out  1      result beat valid
//  out_ready   in   1      downstream accepts result
//  out_result  out  WIDTH  registered result
//  ops_count   out  CNT_W  number of completed output handshakes, wraps mod 2^CNT_W
// BEHAVIOUR
//  Op encoding (01/10/11 identical to the legacy f1f0 select):
//   000 ZERO, 001 AND, 010 OR, 011 XOR, 100 PASS_A, 101 NAND, 110 NOR, 111 XNOR.
//  Pipeline: S1 holds {op,a,b}+s1_v; S2 holds result+s2_v. Result is computed combinationally from S1 into S2.
//  Advance rules:
//   s2_adv = !s2_v | out_ready
//   s1_adv = !s1_v | s2_adv
//   in_ready = s1_adv (combinational, no dependence on in_valid)
//  Input handshake = in_valid & in_ready: load S1, s1_v<=1. Else if s1_adv: s1_v<=0.
//  S2 load when s2_adv: s2_v<=s1_v, result<=op(S1) only if s1_v (data held otherwise).
//  out_valid=s2_v; out_result stable while out_valid & !out_ready.
//  Latency: accept at edge N -> out_valid high after edge N+1 (2 registers). Back-to-back beats: 1 beat/cycle.
//  Full: s1_v & s2_v & !out_ready -> in_ready=0; no beat dropped or duplicated.
//  Empty: out_valid=0; out_result holds last value (don't care to consumer).
//  Simultaneous in accept and out handshake when full: both occur; occupancy unchanged.
//  ops_count += 1 on each out_valid & out_ready; wraps from all-ones to 0, no saturation.
//  Reset (any time, incl. mid-stream): s1_v=s2_v=0, out_valid=0, out_result=0, ops_count=0, in_ready=1 when reset deasserts.
//   In-flight beats discarded.
//  Unused op encodings: none; all 8 defined. X on in_op with in_valid=1 is a bench error.
// CONFIGURATION
//  UNIT_L_PIPE_FLAGS_EN defined: adds out_zero (1b, result==0) and out_parity (1b, ^result) ports.
//   Both registered alongside out_result in S2, same valid and hold rules, reset 0.
//  Not defined: ports and flag registers absent; rest of the behaviour identical.
// STRUCTURE
//  Package unit_l_pkg: typedef enum logic [2:0] op_e (OP_ZERO..OP_XNOR, codes above); OP_W=3 constant.
//  Sub-module unit_l_core: purely combinational WIDTH-bit op_e -> result (case on op). Instantiated once between S1 and S2.
//  Top holds the two pipeline stages, the handshake logic, the counter, and the optional flags.
// TESTING (WIDTH=32, a=32'hDC754CD2, b=32'h4124F055)
//  Per-op sweep, out_ready=1: ops 001/010/011 -> 40244050/DD75FCD7/9D51BC87, each 2 cycles after accept.
//   Ops 101/110/111 -> BFDBBFAF/228A0328/62AE4378. Op 000 -> 0, op 100 -> DC754CD2.
//  Stream 8 beats back-to-back, out_ready=1 -> 8 results in order on consecutive cycles; ops_count=8.
//  Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops after 2 accepts; out_result frozen.
//   Release -> no loss, no duplicate, order kept.
//  Reset asserted with both stages full -> out_valid=0, ops_count=0 immediately (async).
//   First beat after release appears with correct data 2 cycles later.
//  CNT_W=2: 5 handshakes -> ops_count sequence 1,2,3,0,1.
//  With UNIT_L_PIPE_FLAGS_EN: AND of 32'hF0F0F0F0, 32'h0F0F0F0F -> out_zero=1, parity=0.
//   XOR with a=1, b=0 -> out_zero=0, out_parity=1.

Source files
------------

// File: rtl/unit_l_pkg.sv
// Shared op encoding for the pipelined logic unit.
package unit_l_pkg;
   localparam int OP_W = 3;

   // 001/010/011 keep the legacy two-bit select codes
   typedef enum logic [OP_W-1:0] {
      OP_ZERO   = 3'b000,
      OP_AND    = 3'b001,
      OP_OR     = 3'b010,
      OP_XOR    = 3'b011,
      OP_PASS_A = 3'b100,
      OP_NAND   = 3'b101,
      OP_NOR    = 3'b110,
      OP_XNOR   = 3'b111
   } op_e;
endpackage

// File: rtl/unit_l_core.sv
// Combinational bitwise op stage; sits between the two pipeline registers.
module unit_l_core
   import unit_l_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);
   always_comb begin
      result = '0;
      unique case (op)
         OP_ZERO:   result = '0;
         OP_AND:    result = a & b;
         OP_OR:     result = a | b;
         OP_XOR:    result = a ^ b;
         OP_PASS_A: result = a;
         OP_NAND:   result = ~(a & b);
         OP_NOR:    result = ~(a | b);
         OP_XNOR:   result = ~(a ^ b);
         default:   result = '0;
      endcase
   end
endmodule

// File: rtl/unit_l_pipe.sv
// Two-stage valid/ready logic unit with completed-op counter.
// Optional result flags (out_zero, out_parity) under `define UNIT_L_PIPE_FLAGS_EN.
module unit_l_pipe
   import unit_l_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [CNT_W-1:0] ops_count
`ifdef UNIT_L_PIPE_FLAGS_EN
   ,
   output logic             out_zero,
   output logic             out_parity
`endif
);
   logic             s1_v, s2_v;
   logic             s1_adv, s2_adv;
   op_e              s1_op;
   logic [WIDTH-1:0] s1_a, s1_b;
   logic [WIDTH-1:0] core_result;
   logic             in_fire, out_fire;

   // a stage may advance when it is empty or the one after it moves
   assign s2_adv    = !s2_v || out_ready;
   assign s1_adv    = !s1_v || s2_adv;
   assign in_ready  = s1_adv;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = s2_v && out_ready;
   assign out_valid = s2_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         if (in_fire)     s1_v <= 1'b1;
         else if (s1_adv) s1_v <= 1'b0;
         if (s2_adv)      s2_v <= s1_v;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_op <= OP_ZERO;
         s1_a  <= '0;
         s1_b  <= '0;
      end else if (in_fire) begin
         s1_op <= op_e'(in_op);
         s1_a  <= in_a;
         s1_b  <= in_b;
      end
   end

   unit_l_core #(.WIDTH(WIDTH)) u_core (
      .op     (s1_op),
      .a      (s1_a),
      .b      (s1_b),
      .result (core_result)
   );

   // result only reloads on a real beat so it holds across bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 out_result <= '0;
      else if (s2_adv && s1_v) out_result <= core_result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           ops_count <= '0;
      else if (out_fire) ops_count <= ops_count + 1'b1;
   end

`ifdef UNIT_L_PIPE_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_zero   <= 1'b0;
         out_parity <= 1'b0;
      end else if (s2_adv && s1_v) begin
         out_zero   <= (core_result == '0);
         out_parity <= ^core_result;
      end
   end
`endif
endmodule

// File: tb/tb_unit_l_pipe.sv
// Randomized self-checking bench for unit_l_pipe against a queue-based model.
// A second instance with CNT_W=2 shares all inputs to exercise counter wrap.
module tb_unit_l_pipe;
   localparam int WIDTH = 32;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready, in_ready2;
   logic [2:0]       in_op = 3'd0;
   logic [WIDTH-1:0] in_a = '0, in_b = '0;
   logic             out_valid, out_valid2;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_result, out_result2;
   logic [CNT_W-1:0] ops_count;
   logic [1:0]       ops_count2;
`ifdef UNIT_L_PIPE_FLAGS_EN
   logic             out_zero, out_parity, out_zero2, out_parity2;
`endif

   int checks = 0;
   int errors = 0;
   int cnt_model = 0;
   int cyc = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] got_q[$];
   int               got_cyc[$];

   always #5 clk = ~clk;

   unit_l_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .ops_count(ops_count)
`ifdef UNIT_L_PIPE_FLAGS_EN
      , .out_zero(out_zero), .out_parity(out_parity)
`endif
   );

   unit_l_pipe #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid2),
      .out_ready(out_ready), .out_result(out_result2), .ops_count(ops_count2)
`ifdef UNIT_L_PIPE_FLAGS_EN
      , .out_zero(out_zero2), .out_parity(out_parity2)
`endif
   );

   function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a, b);
      case (op)
         3'd0:    return '0;
         3'd1:    return a & b;
         3'd2:    return a | b;
         3'd3:    return a ^ b;
         3'd4:    return a;
         3'd5:    return ~(a & b);
         3'd6:    return ~(a | b);
         default: return ~(a ^ b);
      endcase
   endfunction

   // Inputs only change just after posedge, so negedge sees what the next edge commits.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) exp_q.push_back(ref_op(in_op, in_a, in_b));
         if (out_valid && out_ready) begin
            got_q.push_back(out_result);
            got_cyc.push_back(cyc);
            cnt_model++;
         end
      end
      cyc++;
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_q();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick(3);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      checks++;
      if (ops_count !== '0) begin errors++; $display("FAIL reset_ops_count: got %0d exp 0", ops_count); end
      checks++;
      if (out_result !== '0) begin errors++; $display("FAIL reset_out_result: got %h exp 0", out_result); end
      rst = 1'b0;
      cnt_model = 0;
      clear_q();
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
   endtask

   task automatic test_per_op();
      logic [WIDTH-1:0] exp_tab [8];
      exp_tab = '{32'h0, 32'h40244050, 32'hDD75FCD7, 32'h9D51BC87,
                  32'hDC754CD2, 32'hBFDBBFAF, 32'h228A0328, 32'h62AE4378};
      out_ready = 1'b1;
      for (int op = 0; op < 8; op++) begin
         in_valid = 1'b1; in_op = 3'(op);
         in_a = 32'hDC754CD2; in_b = 32'h4124F055;
         tick();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL op%0d_early_valid: got %b exp 0", op, out_valid); end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_result !== exp_tab[op]) begin
            errors++;
            $display("FAIL op%0d_result: got v=%b %h exp v=1 %h", op, out_valid, out_result, exp_tab[op]);
         end
      end
      tick(2);
      clear_q();
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = cnt_model;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_op = 3'($urandom_range(0, 7));
         in_a = $urandom; in_b = $urandom;
         tick();
      end
      in_valid = 1'b0;
      tick(4);
      checks++;
      if (got_q.size() != 8 || exp_q.size() != 8) begin
         errors++; $display("FAIL stream_count: got %0d exp 8", got_q.size());
      end
      for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
         if (i > 0) begin
            checks++;
            if (got_cyc[i] != got_cyc[i-1] + 1) begin
               errors++; $display("FAIL stream_gap[%0d]: got cycle %0d exp %0d", i, got_cyc[i], got_cyc[i-1] + 1);
            end
         end
      end
      checks++;
      if (ops_count !== 16'(c0 + 8)) begin errors++; $display("FAIL stream_ops_count: got %0d exp %0d", ops_count, 16'(c0 + 8)); end
      clear_q();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_op = 3'($urandom_range(1, 7));
         in_a = $urandom; in_b = $urandom;
         tick();
         if (i >= 1) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b exp 0", i, in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_q[0]) begin
               errors++; $display("FAIL bp_frozen[%0d]: got v=%b %h exp v=1 %h", i, out_valid, out_result, exp_q[0]);
            end
         end
      end
      checks++;
      if (exp_q.size() != 2) begin errors++; $display("FAIL bp_accepts: got %0d exp 2", exp_q.size()); end
      in_valid = 1'b0; out_ready = 1'b1;
      tick(4);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_drain: got %0d exp %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      clear_q();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         in_op = 3'($urandom_range(0, 7));
         in_a = $urandom; in_b = $urandom;
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick(4);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (ops_count !== 16'(cnt_model)) begin errors++; $display("FAIL rand_ops_count: got %0d exp %0d", ops_count, 16'(cnt_model)); end
      clear_q();
   endtask

   task automatic test_reset_mid();
      logic [WIDTH-1:0] a, b, e;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_op = 3'd3; in_a = $urandom; in_b = $urandom;
         tick();
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b exp 0", out_valid); end
      checks++;
      if (ops_count !== '0 || ops_count2 !== '0) begin
         errors++; $display("FAIL midrst_ops_count: got %0d/%0d exp 0", ops_count, ops_count2);
      end
      cnt_model = 0;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      clear_q();
      out_ready = 1'b1;
      a = $urandom; b = $urandom; e = a | b;
      in_valid = 1'b1; in_op = 3'd2; in_a = a; in_b = b;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_result !== e) begin
         errors++; $display("FAIL midrst_first: got v=%b %h exp v=1 %h", out_valid, out_result, e);
      end
      tick(2);
      clear_q();
   endtask

   task automatic test_count_wrap();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      rst = 1'b0; cnt_model = 0;
      clear_q();
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_op = 3'($urandom_range(0, 7)); in_a = $urandom; in_b = $urandom;
         tick();
         in_valid = 1'b0;
         tick(2);
         checks++;
         if (ops_count2 !== 2'((k + 1) % 4)) begin
            errors++; $display("FAIL wrap[%0d]: got %0d exp %0d", k, ops_count2, (k + 1) % 4);
         end
      end
      clear_q();
   endtask

`ifdef UNIT_L_PIPE_FLAGS_EN
   task automatic test_flags();
      out_ready = 1'b1;
      in_valid = 1'b1; in_op = 3'd1; in_a = 32'hF0F0F0F0; in_b = 32'h0F0F0F0F;
      tick();
      in_valid = 1'b1; in_op = 3'd3; in_a = 32'h1; in_b = 32'h0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_zero !== 1'b1 || out_parity !== 1'b0) begin
         errors++; $display("FAIL flags_and: got z=%b p=%b exp z=1 p=0", out_zero, out_parity);
      end
      tick();
      checks++;
      if (out_zero !== 1'b0 || out_parity !== 1'b1) begin
         errors++; $display("FAIL flags_xor: got z=%b p=%b exp z=0 p=1", out_zero, out_parity);
      end
      tick(2);
      clear_q();
   endtask
`endif

   initial begin
      test_reset();
      test_per_op();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_mid();
      test_count_wrap();
`ifdef UNIT_L_PIPE_FLAGS_EN
      test_flags();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
